// File: rtl/score_bcd_acc_pkg.sv
// rtl/score_bcd_acc_pkg.sv - shared state encoding and BCD constants for the score accumulator
package score_bcd_acc_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADD   = 2'd1,
        ST_HSCMP = 2'd2
    } state_t;

endpackage

// File: rtl/score_bcd_acc_bcd_digit_add.sv
// rtl/score_bcd_acc_bcd_digit_add.sv - combinational single BCD digit adder with carry
module bcd_digit_add
    import score_bcd_acc_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    output logic [DIGIT_W-1:0] sum,
    output logic               cout
);

    logic [DIGIT_W:0] raw;
    logic [DIGIT_W:0] adj;

    // Binary add then fold back into 0..9 with a decimal carry
    always_comb begin
        raw  = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
        adj  = raw - 5'd10;
        sum  = raw[DIGIT_W-1:0];
        cout = 1'b0;
        if (raw > {1'b0, BCD_MAX}) begin
            sum  = adj[DIGIT_W-1:0];
            cout = 1'b1;
        end
    end

endmodule

// File: rtl/score_bcd_acc.sv
// rtl/score_bcd_acc.sv - digit-serial BCD score accumulator with saturation and high score
module score_bcd_acc
    import score_bcd_acc_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int V_TOT  = 525
) (
    input  logic                        iClk,
    input  logic                        iRst,
    input  logic                        iClear,
    input  logic                        iScoreInc,
    input  logic [3:0]                  iAddVal,
    input  logic [$clog2(V_TOT)-1:0]    iWindowPos,
    input  logic                        iRoundEnd,
    output logic                        oReady,
    output logic [4*DIGITS-1:0]         oScore,
    output logic [4*DIGITS-1:0]         oHighScore,
    output logic                        oSat,
    output logic                        oNewHigh
);

    localparam int W     = DIGIT_W * DIGITS;
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [W-1:0] ALL_NINES = {DIGITS{BCD_MAX}};

    state_t               state;
    state_t               next_state;
    logic [W-1:0]         acc;
    logic [W-1:0]         acc_upd;
    logic [DIGIT_W-1:0]   addend;
    logic                 carry;
    logic [IDX_W-1:0]     idx;
    logic [W-1:0]         score;
    logic [W-1:0]         high;
    logic                 sat;
    logic                 pending;
    logic                 new_high;

    logic                 inc_ok;
    logic                 last;
    logic [DIGIT_W-1:0]   cur_digit;
    logic [DIGIT_W-1:0]   add_b;
    logic [DIGIT_W-1:0]   sum_digit;
    logic                 carry_out;

    // Single adder shared across digits through the idx mux/demux
    bcd_digit_add u_digit_add (
        .a    (cur_digit),
        .b    (add_b),
        .cin  (carry),
        .sum  (sum_digit),
        .cout (carry_out)
    );

    // Digit select, addend injection on digit 0, and write-back of the updated digit
    always_comb begin
        inc_ok    = iScoreInc && (iWindowPos != '0);
        last      = (idx == IDX_W'(DIGITS - 1));
        cur_digit = acc[int'(idx)*DIGIT_W +: DIGIT_W];
        add_b     = (idx == '0) ? addend : '0;
        acc_upd   = acc;
        acc_upd[int'(idx)*DIGIT_W +: DIGIT_W] = sum_digit;
    end

    // State register
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; clear overrides whatever the current state wants
    always_comb begin
        next_state = state;
        oReady     = (state == ST_IDLE);
        if (iClear) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (inc_ok) begin
                        next_state = ST_ADD;
                    end else if (iRoundEnd) begin
                        next_state = ST_HSCMP;
                    end
                end
                ST_ADD: begin
                    if (last) begin
                        next_state = (pending || iRoundEnd) ? ST_HSCMP : ST_IDLE;
                    end
                end
                ST_HSCMP: next_state = ST_IDLE;
                default:  next_state = ST_IDLE;
            endcase
        end
    end

    // Datapath: accumulator walk, atomic score commit, saturation and high-score update
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            acc      <= '0;
            addend   <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            score    <= '0;
            high     <= '0;
            sat      <= 1'b0;
            pending  <= 1'b0;
            new_high <= 1'b0;
        end else begin
            new_high <= 1'b0;
            if (iClear) begin
                score   <= '0;
                sat     <= 1'b0;
                pending <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (inc_ok) begin
                            acc    <= score;
                            addend <= (iAddVal > BCD_MAX) ? BCD_MAX : iAddVal;
                            idx    <= '0;
                            carry  <= 1'b0;
                            if (iRoundEnd) begin
                                pending <= 1'b1;
                            end
                        end
                    end
                    ST_ADD: begin
                        acc   <= acc_upd;
                        carry <= carry_out;
                        idx   <= idx + IDX_W'(1);
                        if (iRoundEnd) begin
                            pending <= 1'b1;
                        end
                        if (last) begin
                            if (carry_out) begin
                                score <= ALL_NINES;
                                sat   <= 1'b1;
                            end else begin
                                score <= acc_upd;
                            end
                        end
                    end
                    ST_HSCMP: begin
                        pending <= 1'b0;
                        if (score > high) begin
                            high     <= score;
                            new_high <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign oScore     = score;
    assign oHighScore = high;
    assign oSat       = sat;
    assign oNewHigh   = new_high;

endmodule

// File: tb/tb_score_bcd_acc.sv
// tb/tb_score_bcd_acc.sv - directed self-checking bench for score_bcd_acc
module tb_score_bcd_acc;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        inc;
    logic [3:0]  add_val;
    logic [9:0]  win_pos;
    logic        round_end;
    logic        ready;
    logic [15:0] score;
    logic [15:0] high;
    logic        sat;
    logic        new_high;

    int checks;
    int failures;

    score_bcd_acc #(.DIGITS(4), .V_TOT(525)) dut (
        .iClk       (clk),
        .iRst       (rst),
        .iClear     (clr),
        .iScoreInc  (inc),
        .iAddVal    (add_val),
        .iWindowPos (win_pos),
        .iRoundEnd  (round_end),
        .oReady     (ready),
        .oScore     (score),
        .oHighScore (high),
        .oSat       (sat),
        .oNewHigh   (new_high)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic raw_add(input logic [3:0] v);
        int n;
        add_val = v;
        inc     = 1'b1;
        tick();
        inc = 1'b0;
        n   = 0;
        while (!ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("raw_add_timeout", 32'(ready), 32'd1);
    endtask

    task automatic do_add(input string tag, input logic [3:0] v, input logic rnd,
                          input logic [15:0] exp_score, output int pulses);
        int low;
        int n;
        add_val = v;
        inc     = 1'b1;
        tick();
        inc       = 1'b0;
        round_end = rnd;
        low    = 0;
        pulses = 0;
        n      = 0;
        while (!ready && n < 20) begin
            low++;
            if (new_high) pulses++;
            tick();
            round_end = 1'b0;
            n++;
        end
        round_end = 1'b0;
        if (new_high) pulses++;
        check({tag, "_busy"}, 32'(low), rnd ? 32'd5 : 32'd4);
        check({tag, "_score"}, 32'(score), 32'(exp_score));
    endtask

    task automatic do_round_end(input string tag, input logic [15:0] exp_high, input logic exp_pulse);
        round_end = 1'b1;
        tick();
        round_end = 1'b0;
        check({tag, "_busy"}, 32'(ready), 32'd0);
        tick();
        check({tag, "_ready"}, 32'(ready), 32'd1);
        check({tag, "_pulse"}, 32'(new_high), 32'(exp_pulse));
        check({tag, "_high"}, 32'(high), 32'(exp_high));
    endtask

    initial begin
        int p;
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        clr       = 1'b0;
        inc       = 1'b0;
        add_val   = 4'd0;
        win_pos   = 10'd100;
        round_end = 1'b0;
        tick();
        tick();
        check("rst_score", 32'(score), 32'h0000);
        check("rst_high", 32'(high), 32'h0000);
        check("rst_sat", 32'(sat), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_newhigh", 32'(new_high), 32'd0);
        #2 rst = 1'b0;
        tick();

        // reset in the middle of an ADD
        do_add("pre7", 4'd7, 1'b0, 16'h0007, p);
        add_val = 4'd5;
        inc     = 1'b1;
        tick();
        inc = 1'b0;
        tick();
        check("midadd_busy", 32'(ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("midrst_score", 32'(score), 32'h0000);
        check("midrst_high", 32'(high), 32'h0000);
        check("midrst_sat", 32'(sat), 32'd0);
        check("midrst_ready", 32'(ready), 32'd1);
        #2 rst = 1'b0;
        tick();

        // simple adds
        do_add("add7", 4'd7, 1'b0, 16'h0007, p);
        do_add("add5", 4'd5, 1'b0, 16'h0012, p);

        // window gating
        win_pos = 10'd0;
        add_val = 4'd5;
        inc     = 1'b1;
        tick();
        check("win_ready0", 32'(ready), 32'd1);
        tick();
        check("win_ready1", 32'(ready), 32'd1);
        check("win_score", 32'(score), 32'h0012);
        inc     = 1'b0;
        win_pos = 10'd100;

        // carry ripple and clamp
        do_clear();
        check("clr_score", 32'(score), 32'h0000);
        for (int i = 0; i < 111; i++) raw_add(4'd9);
        check("bulk_999", 32'(score), 32'h0999);
        do_add("ripple", 4'd1, 1'b0, 16'h1000, p);
        do_add("clamp", 4'hF, 1'b0, 16'h1009, p);
        do_add("zero", 4'd0, 1'b0, 16'h1009, p);
        check("nosat", 32'(sat), 32'd0);

        // saturation
        do_clear();
        for (int i = 0; i < 1110; i++) raw_add(4'd9);
        raw_add(4'd5);
        check("bulk_9995", 32'(score), 32'h9995);
        do_add("sat7", 4'd7, 1'b0, 16'h9999, p);
        check("sat_flag", 32'(sat), 32'd1);
        do_add("sat3", 4'd3, 1'b0, 16'h9999, p);
        check("sat_sticky", 32'(sat), 32'd1);
        do_clear();
        check("satclr_score", 32'(score), 32'h0000);
        check("satclr_sat", 32'(sat), 32'd0);
        check("satclr_high", 32'(high), 32'h0000);

        // high score
        for (int i = 0; i < 4; i++) raw_add(4'd9);
        raw_add(4'd6);
        check("bulk_42", 32'(score), 32'h0042);
        do_add("hs_add9", 4'd9, 1'b1, 16'h0051, p);
        check("hs_high", 32'(high), 32'h0051);
        check("hs_pulses", 32'(p), 32'd1);
        tick();
        check("hs_pulse_end", 32'(new_high), 32'd0);
        do_clear();
        check("hsclr_high", 32'(high), 32'h0051);
        do_add("low_add3", 4'd3, 1'b0, 16'h0003, p);
        do_round_end("low_re", 16'h0051, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/score_bcd_acc.md
# score_bcd_acc

Parametrised BCD score accumulator for the game datapath. It replaces the fixed two-digit +1 score counter with the following:
- `DIGITS` BCD digits;
- a variable per-request increment of 0–9;
- digit-serial carry propagation;
- sticky saturation;
- a high-score register updated at round end, with a new-record pulse.

It sits between the collision/scoring logic and the score/high-score text renderer.

## Interface
Parameters:
- `DIGITS`, default 4: number of BCD digits (≥2).
- `V_TOT`, default 525: total vertical lines; sets the `iWindowPos` width.

Ports:
- `iClk`, in, 1: system clock.
- `iRst`, in, 1: reset, asynchronous and active-high.
- `iClear`, in, 1: synchronous clear of the score. It does not affect the high score.
- `iScoreInc`, in, 1: increment request.
- `iAddVal`, in, 4: BCD amount to add. Values above 9 are clamped to 9.
- `iWindowPos`, in, `$clog2(V_TOT)`: current vertical line. Increment requests are accepted only when it is non-zero.
- `iRoundEnd`, in, 1: end-of-round strobe. Triggers the high-score compare.
- `oReady`, out, 1: block idle, able to accept `iScoreInc`/`iRoundEnd`.
- `oScore`, out, `4*DIGITS`: packed BCD score, with the most significant digit in the top nibble.
- `oHighScore`, out, `4*DIGITS`: packed BCD high score.
- `oSat`, out, 1: sticky flag, set when the score has saturated at all-9s.
- `oNewHigh`, out, 1: one-cycle pulse when the high score is replaced.

## Operation
- States:
  - IDLE: `oReady`=1.
  - ADD: digit-serial add, `oReady`=0.
  - HSCMP: high-score compare, `oReady`=0.
- **Reset.** On `iRst`:
  - `oScore`=0, `oHighScore`=0, `oSat`=0, `oNewHigh`=0.
  - The pending round-end flag is cleared.
  - The state goes to IDLE, so `oReady`=1.
- **Priority each cycle:** `iClear` first, then the current state's action.
- **`iClear`:**
  - Score becomes 0 and `oSat` becomes 0.
  - Any ADD in progress is aborted and the pending round end is dropped.
  - The state goes to IDLE. The high score is unchanged.
- **IDLE, increment accept.** An increment is accepted when `iScoreInc`=1 and `iWindowPos`≠0. On accept:
  - the working accumulator is loaded from the score;
  - the addend is latched, digit index = 0, carry = 0;
  - the state goes to ADD.
  - Requests that are not accepted are dropped, not queued.
- **IDLE, round end without increment.** `iRoundEnd`=1 with no increment accept moves the state to HSCMP.
- **IDLE, both at once.** If `iRoundEnd`=1 and an increment is accepted in the same cycle, the increment is taken and the round end is latched as pending.
- **ADD, one digit per cycle, LSB first:**
  - sum = digit + (index==0 ? addend : 0) + carry.
  - If sum > 9: digit = sum−10 and carry = 1.
  - Otherwise: digit = sum and carry = 0.
  - ADD always runs exactly `DIGITS` cycles; there is no early exit.
  - `iRoundEnd` arriving during ADD sets the pending flag.
- **ADD, last digit:**
  - If the final carry is 1, the score is set to all-9s and `oSat` is set. Otherwise the accumulator is committed to the score.
  - Next state is HSCMP if a round end is pending, otherwise IDLE.
- **Already saturated.** An increment still runs the full ADD, and the score remains all-9s.
- **Add 0.** Runs the full ADD; the score is unchanged.
- **HSCMP (one cycle):**
  - If score > high score (an unsigned compare of the packed vectors is valid because every digit is ≤9):
    - the high score takes the score;
    - `oNewHigh` pulses for one cycle.
  - Equal or lower: no update and no pulse.
  - The pending flag is cleared and the state goes to IDLE.
  - `iScoreInc` during HSCMP is dropped.

## Timing
- **Acceptance edge.** The increment is accepted at edge E0.
- **`oReady`.** Low for the `DIGITS` cycles after E0, high again after edge E`DIGITS` when the next state is IDLE.
- **Score update.** `oScore` and `oSat` update atomically at edge E`DIGITS`. `oScore` never shows partial digits.
- **High score.** Updates at the edge that ends HSCMP. `oNewHigh` is registered and is high for the single following cycle.
- **Back-to-back increments.** Throughput is one increment per `DIGITS`+1 cycles (the accept cycle plus ADD).
- **Asynchronous reset mid-operation.** Outputs take their reset values immediately. No partial result is committed.

## Structure
- Shared score header/package contains:
  - the state encoding (IDLE/ADD/HSCMP);
  - constant `BCD_MAX`=4'd9;
  - the digit-width constant 4.
- Sub-module `bcd_digit_add`: combinational; 4-bit digit + 4-bit addend + carry-in → 4-bit digit + carry-out. It is instantiated once and reused serially via a digit-select mux/demux on the accumulator.
- The top level holds:
  - the FSM;
  - the accumulator;
  - the digit index counter, `$clog2(DIGITS)` bits;
  - the score, high-score, saturation and pending registers.

## Test plan
All scenarios use `DIGITS`=4.
- **Reset:** assert `iRst` mid-ADD → `oScore`=0000, `oHighScore`=0000, `oSat`=0, `oReady`=1 immediately.
- **Simple adds:** add 7, then add 5 → `oScore`=0012. `oReady` is low for exactly 4 cycles per request.
- **Carry ripple:** 0999 + 1 → 1000. Then add with `iAddVal`=4'hF → 1009 (clamped to 9).
- **Saturation:** from 9995 add 7 → 9999 and `oSat`=1. Add 3 → still 9999 and `oSat` still 1. `iClear` → 0000, `oSat`=0, high score unchanged.
- **Window gating:** `iScoreInc` with `iWindowPos`=0 → no accept, `oReady` stays 1, score unchanged.
- **High score:**
  - From score 0042, add 9 with `iRoundEnd` asserted during ADD → score 0051, then the high score becomes 0051 with one `oNewHigh` pulse.
  - `iClear`, add 3, `iRoundEnd` → high score stays 0051, no pulse.
